sdram_device_responder: RTL and testbench
=========================================

# sdram_device_responder

Cycle-accurate SDRAM device-side responder for the `sdram_controller` command bus. It decodes the controller's command and address pins, tracks the open row in each of 4 banks, stores written words in a small internal array, and returns read data after the configured CAS latency. Protocol violations are flagged on `cmd_error`. It sits on the controller's SDRAM side, in simulation benches and in FPGA loop-back builds, in place of a real SDRAM.

## Interface
- `CAS_LATENCY`, 2: read latency in clocks; legal values are 2 and 3.
- `MEM_ADDR_BITS`, 8: storage depth is 2^MEM_ADDR_BITS 16-bit words; must be 8.
- `clk` in 1: single clock. All activity is on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `clock_enable` in 1: when 0, the sampled command is treated as NOP.
- `cs_n`, `ras_n`, `cas_n`, `we_n` in 1 each: command pins.
- `addr` in 13: row address for ACTIVE, column address for READ/WRITE, A10 selects all banks for PRECHARGE, mode value for LOAD MODE.
- `bank_addr` in 2: bank select.
- `ctrl_data` in 16: write data from the controller (the controller's `data_out`).
- `ctrl_data_oe` in 1: controller is driving `ctrl_data` (the controller's `data_oe`).
- `data_mask_low`, `data_mask_high` in 1 each: write byte masks; 1 blocks the byte.
- `dq_out` out 16: read data to the controller (feeds the controller's `data_in`).
- `dq_oe` out 1: responder drives `dq_out` this cycle.
- `cmd_error` out 1: one-cycle pulse on a protocol violation.
- `mode_reg` out 13: last accepted LOAD MODE value.
- `bank_open` out 4: per-bank row-open flags.
- `refresh_count` out 16: count of accepted AUTO REFRESH commands; wraps at 0xFFFF→0.

## Operation
- Command decode uses {cs_n, ras_n, cas_n, we_n}:
  - 1xxx: DESELECT, treated as NOP.
  - 0111: NOP.
  - 0011: ACTIVE.
  - 0101: READ.
  - 0100: WRITE.
  - 0010: PRECHARGE.
  - 0001: AUTO REFRESH.
  - 0000: LOAD MODE.
  - 0110: BURST TERMINATE, treated as NOP.
- Burst length is fixed at 1. `mode_reg` is informational only; latency always comes from `CAS_LATENCY`.
- ACTIVE:
  - Bank idle: set `bank_open[b]` and latch `row[b] = addr`.
  - Bank already open: `cmd_error`; row and flag unchanged.
- PRECHARGE:
  - `addr[10]`=1: close all banks.
  - `addr[10]`=0: close bank `bank_addr` only.
  - Precharging an idle bank is legal and raises no error.
- AUTO REFRESH:
  - All banks idle: `refresh_count` += 1.
  - Otherwise: `cmd_error`; count unchanged.
- LOAD MODE:
  - All banks idle: `mode_reg <= addr`.
  - Otherwise: `cmd_error`; register unchanged.
- Storage index = {bank_addr, row[bank][2:0], addr[2:0]} (8 bits). Higher row and column bits are ignored (aliasing).
- WRITE to an open bank:
  - Requires `ctrl_data_oe`=1.
  - Writes `ctrl_data` into the indexed word at the same edge; each byte is skipped when its mask is 1.
  - `ctrl_data_oe`=0: no write, `cmd_error`.
- READ to an open bank: the word is sampled at the command edge and enters the latency pipeline. Masks are ignored on reads.
- READ or WRITE to a closed bank: no access, `cmd_error`.
- Bus contention: WRITE sampled while `dq_oe`=1 raises `cmd_error`; the write is still performed.
- Storage contents are not reset.

## Timing
- Reset values: `dq_out`=0, `dq_oe`=0, `cmd_error`=0, `mode_reg`=0, `bank_open`=0, `refresh_count`=0. All row registers are 0 and the read pipeline is empty.
- Reset during a pending read discards it; `dq_oe` stays 0.
- Read latency: READ sampled at edge k → `dq_out`/`dq_oe` update at edge k+CAS_LATENCY−1. They hold for exactly one cycle and are stable at edge k+CAS_LATENCY, where the controller samples them.
- `dq_oe` returns to 0 at the next edge unless another READ is in flight.
- Back-to-back READs on consecutive edges give back-to-back data with `dq_oe` held high continuously.
- A WRITE at edge k to the address of a READ at edge k−1 does not affect the data returned by that READ (old data).
- A WRITE at edge k followed by a READ at edge k+1 to the same address returns the new data.
- `cmd_error` is registered: it is high for the one cycle following the offending edge.
- Status outputs (`bank_open`, `mode_reg`, `refresh_count`) update at the command edge.
- PRECHARGE and ACTIVE to the same bank on consecutive edges are legal; no tRP/tRCD is enforced.

## Test plan
- Reset, then LOAD MODE with addr=0x020 → `mode_reg`=0x020, no error. Then ACTIVE bank0 row 5 → `bank_open`=4'b0001.
- WRITE bank0 col 3 data 0xA5C3 with masks 0/0, then READ bank0 col 3 at edge k → `dq_out`=0xA5C3 with `dq_oe`=1 stable at edge k+2 (CL=2), and `dq_oe`=0 at edge k+3.
- WRITE 0xFFFF with `data_mask_high`=1 over existing 0x1234 → a later READ returns 0x12FF.
- READ bank2 with `bank_open[2]`=0 → `cmd_error` pulses once, `dq_oe` stays 0. ACTIVE bank0 twice → `cmd_error` on the second ACTIVE.
- AUTO REFRESH with bank0 open → `cmd_error`, `refresh_count`=0. Then PRECHARGE with A10=1 followed by AUTO REFRESH ×3 → `bank_open`=0, `refresh_count`=3.
- READs on 4 consecutive edges to cols 0–3 holding 0x0001–0x0004 → `dq_oe` high for 4 consecutive cycles with data in order. Assert `rst` mid-burst → `dq_oe`=0 on the next cycle.

Source files
------------

// File: rtl/sdram_device_responder.sv
// SDRAM device-side responder: decodes controller commands, tracks the open row per bank,
// stores words in a small array and returns read data after CAS_LATENCY clocks.
module sdram_device_responder #(
    parameter int unsigned CAS_LATENCY   = 2,
    parameter int unsigned MEM_ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clock_enable,
    input  logic        cs_n,
    input  logic        ras_n,
    input  logic        cas_n,
    input  logic        we_n,
    input  logic [12:0] addr,
    input  logic [1:0]  bank_addr,
    input  logic [15:0] ctrl_data,
    input  logic        ctrl_data_oe,
    input  logic        data_mask_low,
    input  logic        data_mask_high,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic        cmd_error,
    output logic [12:0] mode_reg,
    output logic [3:0]  bank_open,
    output logic [15:0] refresh_count
);

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned ADDR_W     = 13;
    localparam int unsigned NUM_BANKS  = 4;
    localparam int unsigned ROW_BITS   = 3;
    localparam int unsigned COL_BITS   = 3;
    localparam int unsigned PIPE_DEPTH = CAS_LATENCY - 1;
    localparam int unsigned MEM_DEPTH  = 1 << MEM_ADDR_BITS;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACTIVE,
        CMD_READ,
        CMD_WRITE,
        CMD_PRECHARGE,
        CMD_REFRESH,
        CMD_LOAD_MODE
    } cmd_e;

    cmd_e cmd;

    logic [DATA_W-1:0]        mem_q [MEM_DEPTH];
    logic [ROW_BITS-1:0]      row_q [NUM_BANKS];
    logic [ROW_BITS-1:0]      row_d [NUM_BANKS];
    logic [NUM_BANKS-1:0]     bank_open_q, bank_open_d;
    logic [ADDR_W-1:0]        mode_reg_q, mode_reg_d;
    logic [DATA_W-1:0]        refresh_count_q, refresh_count_d;
    logic                     cmd_error_q, cmd_error_d;
    logic [PIPE_DEPTH-1:0]    pipe_valid_q, pipe_valid_d;
    logic [DATA_W-1:0]        pipe_data_q [PIPE_DEPTH];
    logic [DATA_W-1:0]        pipe_data_d [PIPE_DEPTH];
    logic                     dq_oe_q, dq_oe_d;
    logic [DATA_W-1:0]        dq_out_q, dq_out_d;

    logic                     mem_we;
    logic [MEM_ADDR_BITS-1:0] mem_idx;
    logic [DATA_W-1:0]        mem_rdata;
    logic [DATA_W-1:0]        mem_wdata;
    logic                     rd_issue;

    // Command decode; a low clock enable or deselected chip reads as NOP.
    always_comb begin
        cmd = CMD_NOP;
        if (clock_enable && !cs_n) begin
            case ({ras_n, cas_n, we_n})
                3'b011:  cmd = CMD_ACTIVE;
                3'b101:  cmd = CMD_READ;
                3'b100:  cmd = CMD_WRITE;
                3'b010:  cmd = CMD_PRECHARGE;
                3'b001:  cmd = CMD_REFRESH;
                3'b000:  cmd = CMD_LOAD_MODE;
                default: cmd = CMD_NOP;
            endcase
        end
    end

    // Only the low row/column bits select storage, so wider addresses alias.
    always_comb begin
        mem_idx   = MEM_ADDR_BITS'({bank_addr, row_q[bank_addr], addr[COL_BITS-1:0]});
        mem_rdata = mem_q[mem_idx];
        mem_wdata = {data_mask_high ? mem_rdata[15:8] : ctrl_data[15:8],
                     data_mask_low  ? mem_rdata[7:0]  : ctrl_data[7:0]};
    end

    always_comb begin
        bank_open_d     = bank_open_q;
        row_d           = row_q;
        mode_reg_d      = mode_reg_q;
        refresh_count_d = refresh_count_q;
        cmd_error_d     = 1'b0;
        mem_we          = 1'b0;
        rd_issue        = 1'b0;

        case (cmd)
            CMD_ACTIVE: begin
                if (bank_open_q[bank_addr]) begin
                    cmd_error_d = 1'b1;
                end else begin
                    bank_open_d[bank_addr] = 1'b1;
                    row_d[bank_addr]       = addr[ROW_BITS-1:0];
                end
            end
            CMD_READ: begin
                if (bank_open_q[bank_addr]) rd_issue = 1'b1;
                else                        cmd_error_d = 1'b1;
            end
            CMD_WRITE: begin
                // Contention is flagged but a legal write still lands.
                if (dq_oe_q) cmd_error_d = 1'b1;
                if (!bank_open_q[bank_addr] || !ctrl_data_oe) cmd_error_d = 1'b1;
                else                                          mem_we = 1'b1;
            end
            CMD_PRECHARGE: begin
                if (addr[10]) bank_open_d = '0;
                else          bank_open_d[bank_addr] = 1'b0;
            end
            CMD_REFRESH: begin
                if (bank_open_q != '0) cmd_error_d = 1'b1;
                else                   refresh_count_d = refresh_count_q + DATA_W'(1);
            end
            CMD_LOAD_MODE: begin
                if (bank_open_q != '0) cmd_error_d = 1'b1;
                else                   mode_reg_d = addr;
            end
            default: ;
        endcase
    end

    // Read latency pipeline; the word is captured at the command edge.
    always_comb begin
        pipe_valid_d[0] = rd_issue;
        pipe_data_d[0]  = mem_rdata;
        for (int i = 1; i < int'(PIPE_DEPTH); i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_data_d[i]  = pipe_data_q[i-1];
        end
        dq_oe_d  = pipe_valid_q[PIPE_DEPTH-1];
        dq_out_d = pipe_valid_q[PIPE_DEPTH-1] ? pipe_data_q[PIPE_DEPTH-1] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_open_q     <= '0;
            mode_reg_q      <= '0;
            refresh_count_q <= '0;
            cmd_error_q     <= 1'b0;
            pipe_valid_q    <= '0;
            dq_oe_q         <= 1'b0;
            dq_out_q        <= '0;
            for (int b = 0; b < int'(NUM_BANKS); b++) row_q[b] <= '0;
            for (int i = 0; i < int'(PIPE_DEPTH); i++) pipe_data_q[i] <= '0;
        end else begin
            bank_open_q     <= bank_open_d;
            row_q           <= row_d;
            mode_reg_q      <= mode_reg_d;
            refresh_count_q <= refresh_count_d;
            cmd_error_q     <= cmd_error_d;
            pipe_valid_q    <= pipe_valid_d;
            pipe_data_q     <= pipe_data_d;
            dq_oe_q         <= dq_oe_d;
            dq_out_q        <= dq_out_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_idx] <= mem_wdata;
    end

    assign dq_out        = dq_out_q;
    assign dq_oe         = dq_oe_q;
    assign cmd_error     = cmd_error_q;
    assign mode_reg      = mode_reg_q;
    assign bank_open     = bank_open_q;
    assign refresh_count = refresh_count_q;

endmodule

// File: tb/tb_sdram_device_responder.sv
// Bench for sdram_device_responder: directed scenarios plus a randomized command stream
// checked against a behavioural model of banks, storage and read returns.
module tb_sdram_device_responder;

    localparam int unsigned CL = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clock_enable = 1'b1;
    logic        cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [12:0] addr = '0;
    logic [1:0]  bank_addr = '0;
    logic [15:0] ctrl_data = '0;
    logic        ctrl_data_oe = 1'b0;
    logic        data_mask_low = 1'b0, data_mask_high = 1'b0;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        cmd_error;
    logic [12:0] mode_reg;
    logic [3:0]  bank_open;
    logic [15:0] refresh_count;

    sdram_device_responder #(.CAS_LATENCY(CL), .MEM_ADDR_BITS(8)) dut (
        .clk(clk), .rst(rst), .clock_enable(clock_enable),
        .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
        .addr(addr), .bank_addr(bank_addr), .ctrl_data(ctrl_data),
        .ctrl_data_oe(ctrl_data_oe), .data_mask_low(data_mask_low),
        .data_mask_high(data_mask_high), .dq_out(dq_out), .dq_oe(dq_oe),
        .cmd_error(cmd_error), .mode_reg(mode_reg), .bank_open(bank_open),
        .refresh_count(refresh_count)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    typedef struct { int due; logic [15:0] data; bit known; } rd_t;
    logic [15:0] m_mem [256];
    bit          m_known [256];
    logic [12:0] m_row [4];
    logic [3:0]  m_open = '0;
    logic [12:0] m_mode = '0;
    logic [15:0] m_count = '0;
    rd_t         rdq [$];
    bit          exp_oe = 0, exp_err = 0, exp_known = 0;
    logic [15:0] exp_out = '0;
    int          edge_cnt = 0;
    int          n_checks = 0, n_errors = 0;

    // Advance one clock edge, applying the currently driven pins to the model.
    task automatic do_edge();
        logic [3:0] p;
        int idx;
        bit err;
        rd_t r;
        if (rst) begin
            @(posedge clk); #1;
            edge_cnt++;
            m_open = '0; m_mode = '0; m_count = '0;
            for (int b = 0; b < 4; b++) m_row[b] = '0;
            rdq.delete();
            exp_oe = 0; exp_err = 0; exp_out = '0;
            return;
        end
        p = {cs_n, ras_n, cas_n, we_n};
        if (!clock_enable || cs_n) p = 4'b0111;
        err = 0;
        idx = {bank_addr, m_row[bank_addr][2:0], addr[2:0]};
        case (p)
            4'b0011: if (m_open[bank_addr]) err = 1;
                     else begin m_open[bank_addr] = 1'b1; m_row[bank_addr] = addr; end
            4'b0101: if (m_open[bank_addr]) begin
                         r.due = edge_cnt + CL; r.data = m_mem[idx]; r.known = m_known[idx];
                         rdq.push_back(r);
                     end else err = 1;
            4'b0100: begin
                if (exp_oe) err = 1;
                if (!m_open[bank_addr] || !ctrl_data_oe) err = 1;
                else begin
                    if (!data_mask_high) m_mem[idx][15:8] = ctrl_data[15:8];
                    if (!data_mask_low)  m_mem[idx][7:0]  = ctrl_data[7:0];
                    m_known[idx] = m_known[idx] || (!data_mask_high && !data_mask_low);
                end
            end
            4'b0010: if (addr[10]) m_open = '0; else m_open[bank_addr] = 1'b0;
            4'b0001: if (m_open != 0) err = 1; else m_count = m_count + 16'd1;
            4'b0000: if (m_open != 0) err = 1; else m_mode = addr;
            default: ;
        endcase
        @(posedge clk); #1;
        edge_cnt++;
        exp_err = err;
        if (rdq.size() > 0 && rdq[0].due == edge_cnt) begin
            exp_oe = 1; exp_out = rdq[0].data; exp_known = rdq[0].known;
            void'(rdq.pop_front());
        end else begin
            exp_oe = 0;
        end
    endtask

    task automatic drive(input logic [3:0] pins, input logic [12:0] a, input logic [1:0] ba,
                         input logic [15:0] d, input logic doe, input logic mh, input logic ml);
        clock_enable = 1'b1;
        {cs_n, ras_n, cas_n, we_n} = pins;
        addr = a; bank_addr = ba; ctrl_data = d; ctrl_data_oe = doe;
        data_mask_high = mh; data_mask_low = ml;
        do_edge();
    endtask

    task automatic cmd_nop();                                    drive(4'b0111, '0, '0, '0, 0, 0, 0); endtask
    task automatic cmd_active(input logic [1:0] b, input logic [12:0] row); drive(4'b0011, row, b, '0, 0, 0, 0); endtask
    task automatic cmd_read(input logic [1:0] b, input logic [12:0] col);   drive(4'b0101, col, b, '0, 0, 0, 0); endtask
    task automatic cmd_write(input logic [1:0] b, input logic [12:0] col, input logic [15:0] d,
                             input logic mh, input logic ml, input logic doe);
        drive(4'b0100, col, b, d, doe, mh, ml);
    endtask
    task automatic cmd_pre(input logic [1:0] b, input bit all);  drive(4'b0010, all ? 13'h400 : 13'h000, b, '0, 0, 0, 0); endtask
    task automatic cmd_ref();                                    drive(4'b0001, '0, '0, '0, 0, 0, 0); endtask
    task automatic cmd_lmr(input logic [12:0] v);                drive(4'b0000, v, '0, '0, 0, 0, 0); endtask
    task automatic do_reset();
        rst = 1'b1; {cs_n, ras_n, cas_n, we_n} = 4'b0111;
        do_edge();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (dq_oe !== 1'b0)          begin n_errors++; $display("FAIL reset_dq_oe: got %0b exp 0", dq_oe); end
        n_checks++; if (dq_out !== 16'h0)        begin n_errors++; $display("FAIL reset_dq_out: got %h exp 0000", dq_out); end
        n_checks++; if (cmd_error !== 1'b0)      begin n_errors++; $display("FAIL reset_cmd_error: got %0b exp 0", cmd_error); end
        n_checks++; if (mode_reg !== 13'h0)      begin n_errors++; $display("FAIL reset_mode_reg: got %h exp 0", mode_reg); end
        n_checks++; if (bank_open !== 4'h0)      begin n_errors++; $display("FAIL reset_bank_open: got %b exp 0000", bank_open); end
        n_checks++; if (refresh_count !== 16'h0) begin n_errors++; $display("FAIL reset_refresh_count: got %h exp 0", refresh_count); end
    endtask

    task automatic test_mode_active();
        cmd_lmr(13'h020);
        n_checks++; if (mode_reg !== 13'h020) begin n_errors++; $display("FAIL lmr_value: got %h exp 020", mode_reg); end
        n_checks++; if (cmd_error !== 1'b0)   begin n_errors++; $display("FAIL lmr_error: got %0b exp 0", cmd_error); end
        cmd_active(2'd0, 13'd5);
        n_checks++; if (bank_open !== 4'b0001) begin n_errors++; $display("FAIL active_open: got %b exp 0001", bank_open); end
        n_checks++; if (cmd_error !== 1'b0)    begin n_errors++; $display("FAIL active_error: got %0b exp 0", cmd_error); end
    endtask

    task automatic test_write_read();
        cmd_write(2'd0, 13'd3, 16'hA5C3, 0, 0, 1);
        n_checks++; if (cmd_error !== 1'b0) begin n_errors++; $display("FAIL wr_error: got %0b exp 0", cmd_error); end
        cmd_read(2'd0, 13'd3);
        n_checks++; if (dq_oe !== 1'b0) begin n_errors++; $display("FAIL rd_early_oe: got %0b exp 0", dq_oe); end
        cmd_nop();
        n_checks++; if (dq_oe !== 1'b1 || dq_out !== 16'hA5C3)
            begin n_errors++; $display("FAIL rd_data: got oe=%0b %h exp oe=1 A5C3", dq_oe, dq_out); end
        cmd_nop();
        n_checks++; if (dq_oe !== 1'b0) begin n_errors++; $display("FAIL rd_oe_drop: got %0b exp 0", dq_oe); end
        // read then write the same word: old data returns, later read sees new data
        cmd_read(2'd0, 13'd3);
        cmd_write(2'd0, 13'd3, 16'h5A5A, 0, 0, 1);
        n_checks++; if (dq_oe !== 1'b1 || dq_out !== 16'hA5C3)
            begin n_errors++; $display("FAIL war_old_data: got oe=%0b %h exp oe=1 A5C3", dq_oe, dq_out); end
        cmd_read(2'd0, 13'd3);
        cmd_nop();
        n_checks++; if (dq_oe !== 1'b1 || dq_out !== 16'h5A5A)
            begin n_errors++; $display("FAIL raw_new_data: got oe=%0b %h exp oe=1 5A5A", dq_oe, dq_out); end
    endtask

    task automatic test_mask();
        cmd_write(2'd0, 13'd4, 16'h1234, 0, 0, 1);
        cmd_write(2'd0, 13'd4, 16'hFFFF, 1, 0, 1);
        cmd_read(2'd0, 13'd4);
        cmd_nop();
        n_checks++; if (dq_out !== 16'h12FF) begin n_errors++; $display("FAIL mask_high: got %h exp 12FF", dq_out); end
        cmd_write(2'd0, 13'd5, 16'hBEEF, 0, 0, 1);
        cmd_write(2'd0, 13'd5, 16'h0000, 0, 1, 1);
        cmd_read(2'd0, 13'd5);
        cmd_nop();
        n_checks++; if (dq_out !== 16'h00EF) begin n_errors++; $display("FAIL mask_low: got %h exp 00EF", dq_out); end
    endtask

    task automatic test_errors();
        cmd_read(2'd2, 13'd0);
        n_checks++; if (cmd_error !== 1'b1) begin n_errors++; $display("FAIL closed_read_err: got %0b exp 1", cmd_error); end
        cmd_nop();
        n_checks++; if (cmd_error !== 1'b0 || dq_oe !== 1'b0)
            begin n_errors++; $display("FAIL closed_read_after: got err=%0b oe=%0b exp 0 0", cmd_error, dq_oe); end
        cmd_nop();
        n_checks++; if (dq_oe !== 1'b0) begin n_errors++; $display("FAIL closed_read_oe: got %0b exp 0", dq_oe); end
        cmd_active(2'd0, 13'd7);
        n_checks++; if (cmd_error !== 1'b1 || bank_open !== 4'b0001)
            begin n_errors++; $display("FAIL double_active: got err=%0b open=%b exp 1 0001", cmd_error, bank_open); end
        cmd_read(2'd0, 13'd3);
        cmd_nop();
        n_checks++; if (dq_out !== 16'h5A5A) begin n_errors++; $display("FAIL row_kept: got %h exp 5A5A", dq_out); end
        cmd_write(2'd0, 13'd6, 16'h1111, 0, 0, 0);
        n_checks++; if (cmd_error !== 1'b1) begin n_errors++; $display("FAIL write_no_oe: got %0b exp 1", cmd_error); end
        cmd_read(2'd0, 13'd3);
        cmd_nop();
        cmd_write(2'd0, 13'd6, 16'h7777, 0, 0, 1);
        n_checks++; if (cmd_error !== 1'b1) begin n_errors++; $display("FAIL contention_err: got %0b exp 1", cmd_error); end
        cmd_read(2'd0, 13'd6);
        cmd_nop();
        n_checks++; if (dq_out !== 16'h7777) begin n_errors++; $display("FAIL contention_write: got %h exp 7777", dq_out); end
    endtask

    task automatic test_refresh();
        cmd_ref();
        n_checks++; if (cmd_error !== 1'b1 || refresh_count !== 16'd0)
            begin n_errors++; $display("FAIL ref_open: got err=%0b cnt=%0d exp 1 0", cmd_error, refresh_count); end
        cmd_pre(2'd2, 0);
        n_checks++; if (cmd_error !== 1'b0) begin n_errors++; $display("FAIL pre_idle: got %0b exp 0", cmd_error); end
        cmd_pre(2'd0, 1);
        for (int i = 0; i < 3; i++) cmd_ref();
        n_checks++; if (bank_open !== 4'b0000 || refresh_count !== 16'd3)
            begin n_errors++; $display("FAIL ref_count: got open=%b cnt=%0d exp 0000 3", bank_open, refresh_count); end
    endtask

    task automatic test_back_to_back();
        cmd_active(2'd1, 13'd2);
        for (int i = 0; i < 4; i++) cmd_write(2'd1, 13'(i), 16'(i + 1), 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) cmd_read(2'd1, 13'(i)); else cmd_nop();
            if (i > 0) begin
                n_checks++; if (dq_oe !== 1'b1 || dq_out !== 16'(i))
                    begin n_errors++; $display("FAIL b2b_%0d: got oe=%0b %h exp oe=1 %h", i, dq_oe, dq_out, 16'(i)); end
            end
        end
        cmd_nop();
        n_checks++; if (dq_oe !== 1'b0) begin n_errors++; $display("FAIL b2b_end: got %0b exp 0", dq_oe); end
        for (int i = 0; i < 3; i++) cmd_read(2'd1, 13'(i));
        do_reset();
        n_checks++; if (dq_oe !== 1'b0) begin n_errors++; $display("FAIL rst_mid_oe: got %0b exp 0", dq_oe); end
        cmd_nop();
        n_checks++; if (dq_oe !== 1'b0 || bank_open !== 4'b0000)
            begin n_errors++; $display("FAIL rst_mid_after: got oe=%0b open=%b exp 0 0000", dq_oe, bank_open); end
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 800; n++) begin
            r = int'($urandom_range(0, 99));
            clock_enable = ($urandom_range(0, 19) != 0);
            bank_addr = 2'($urandom_range(0, 3));
            addr = 13'($urandom) & 13'h1FF9;
            ctrl_data = 16'($urandom);
            ctrl_data_oe = ($urandom_range(0, 9) != 0);
            data_mask_high = ($urandom_range(0, 5) == 0);
            data_mask_low = ($urandom_range(0, 5) == 0);
            if (r < 12)      {cs_n, ras_n, cas_n, we_n} = 4'b0011;
            else if (r < 42) {cs_n, ras_n, cas_n, we_n} = 4'b0101;
            else if (r < 72) {cs_n, ras_n, cas_n, we_n} = 4'b0100;
            else if (r < 82) {cs_n, ras_n, cas_n, we_n} = 4'b0010;
            else if (r < 86) {cs_n, ras_n, cas_n, we_n} = 4'b0001;
            else if (r < 89) {cs_n, ras_n, cas_n, we_n} = 4'b0000;
            else if (r < 92) {cs_n, ras_n, cas_n, we_n} = 4'b0110;
            else if (r < 95) {cs_n, ras_n, cas_n, we_n} = {1'b1, 3'($urandom)};
            else             {cs_n, ras_n, cas_n, we_n} = 4'b0111;
            rst = ($urandom_range(0, 99) == 0);
            do_edge();
            rst = 1'b0;
            n_checks++; if (dq_oe !== exp_oe) begin n_errors++; $display("FAIL rnd_oe@%0d: got %0b exp %0b", n, dq_oe, exp_oe); end
            n_checks++; if (cmd_error !== exp_err) begin n_errors++; $display("FAIL rnd_err@%0d: got %0b exp %0b", n, cmd_error, exp_err); end
            n_checks++; if (bank_open !== m_open) begin n_errors++; $display("FAIL rnd_open@%0d: got %b exp %b", n, bank_open, m_open); end
            n_checks++; if (mode_reg !== m_mode) begin n_errors++; $display("FAIL rnd_mode@%0d: got %h exp %h", n, mode_reg, m_mode); end
            n_checks++; if (refresh_count !== m_count) begin n_errors++; $display("FAIL rnd_refresh@%0d: got %0d exp %0d", n, refresh_count, m_count); end
            if (exp_oe && exp_known) begin
                n_checks++; if (dq_out !== exp_out) begin n_errors++; $display("FAIL rnd_data@%0d: got %h exp %h", n, dq_out, exp_out); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode_active();
        test_write_read();
        test_mask();
        test_errors();
        test_refresh();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
